// File: rtl/bus_arbiter_if.sv
// ============================================================================
// Module  : bus_arbiter_if
// Brief   : Requester-side and memory-side signal bundle for bus_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 32
);
  logic [NREQ-1:0]           REQ_VALID;
  logic [NREQ-1:0]           REQ_WR;
  logic [NREQ-1:0][AW-1:0]   REQ_ADDR;
  logic [NREQ-1:0][31:0]     REQ_WDATA;
  logic [NREQ-1:0][3:0]      REQ_BE;
  logic [NREQ-1:0]           REQ_READY;
  logic [NREQ-1:0]           RSP_VALID;
  logic [31:0]               RSP_RDATA;
  logic                      MEM_EN;
  logic [3:0]                MEM_WE;
  logic [AW-1:0]             MEM_ADDR;
  logic [31:0]               MEM_WDATA;
  logic [31:0]               MEM_RDATA;
  logic [1:0]                GRANT;

  // Arbiter side
  modport slave (
    input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, REQ_BE, MEM_RDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, MEM_EN, MEM_WE, MEM_ADDR,
           MEM_WDATA, GRANT
  );

  // Requester / memory side
  modport master (
    output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, REQ_BE, MEM_RDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, MEM_EN, MEM_WE, MEM_ADDR,
           MEM_WDATA, GRANT
  );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module  : bus_arbiter
// Brief   : Round-robin arbiter sharing one single-cycle memory port among
//           NREQ (<= 4) requesters; one transaction every three cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 32
) (
  input  wire logic     XCLK,
  input  wire logic     XRES,
  bus_arbiter_if.slave  bus
);

  localparam int c_IW = 2;
  localparam int c_CW = c_IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_IW-1:0]   r_ptr;
  logic [c_IW-1:0]   r_win;
  logic              r_wr;
  logic [AW-1:0]     r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_rdata;

  logic              w_found;
  logic [c_IW-1:0]   w_pick;
  logic [c_CW-1:0]   w_cand;
  logic              w_latch;
  logic [NREQ-1:0]   w_ready;
  logic [NREQ-1:0]   w_rsp;
  logic              w_mem_en;
  logic [3:0]        w_mem_we;

  // Search from the priority pointer upward, wrapping at NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = c_CW'(r_ptr) + c_CW'(k);
      if (w_cand >= c_CW'(NREQ))
        w_cand = w_cand - c_CW'(NREQ);
      if (!w_found && bus.REQ_VALID[w_cand[c_IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[c_IW-1:0];
      end
    end
  end

  assign w_latch = w_found && ((r_state == IDLE) || (r_state == RESP));

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_rsp       = '0;
    w_mem_en    = 1'b0;
    w_mem_we    = 4'b0000;
    case (r_state)
      IDLE: begin
        if (w_found)
          w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_mem_en       = 1'b1;
        w_mem_we       = r_wr ? r_be : 4'b0000;
        w_ready[r_win] = 1'b1;
        w_state_nxt    = WAIT;
      end
      WAIT: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        w_rsp[r_win] = 1'b1;
        w_state_nxt  = w_found ? ISSUE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch and read-data capture; the latch isolates the in-flight
  // access from requester changes after selection.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      r_ptr   <= '0;
      r_win   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      if (w_latch) begin
        r_win   <= w_pick;
        r_wr    <= bus.REQ_WR[w_pick];
        r_addr  <= bus.REQ_ADDR[w_pick];
        r_wdata <= bus.REQ_WDATA[w_pick];
        r_be    <= bus.REQ_BE[w_pick];
        r_ptr   <= (w_pick == c_IW'(NREQ - 1)) ? '0 : w_pick + 1'b1;
      end
      if ((r_state == WAIT) && !r_wr)
        r_rdata <= bus.MEM_RDATA;
    end
  end

  assign bus.REQ_READY = w_ready;
  assign bus.RSP_VALID = w_rsp;
  assign bus.RSP_RDATA = r_rdata;
  assign bus.MEM_EN    = w_mem_en;
  assign bus.MEM_WE    = w_mem_we;
  assign bus.MEM_ADDR  = r_addr;
  assign bus.MEM_WDATA = r_wdata;
  assign bus.GRANT     = r_win;

endmodule

`default_nettype wire
